uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
- Transmit half of the word-oriented serial link between the processor-under-test controller and the host PC.
- Accepts 32-bit words from the command interpreter into a word FIFO.
- Sends each word as WORD_SIZE_BY bytes, least-significant byte first, as 8N1 frames on tx.
- Paired with the existing receive path; shares its bit-rate arithmetic.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz
BIT_RATE, 9600, serial bit rate in bits/s
PAYLOAD_BITS, 8, data bits per serial frame
BUFFER_SIZE, 8, FIFO depth in words (power of two, >= 2)
WORD_SIZE_BY, 4, bytes per word (WORD_SIZE_BY*PAYLOAD_BITS = 32)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
write  input  1  push strobe, one word per cycle high
write_data  input  32  word to transmit
full  output  1  registered; FIFO holds BUFFER_SIZE words
busy  output  1  registered; FIFO non-empty or a frame in progress
overflow  output  1  sticky; set when write is high while full is high
tx  output  1  serial line, idles high

Behaviour:
- CYCLES_PER_BIT = CLK_FREQ / BIT_RATE, integer division. Each bit period is exactly CYCLES_PER_BIT clk cycles, counted by a down-counter.
- Reset asserted (async, immediate, including mid-frame):
  - tx=1, full=0, busy=0, overflow=0.
  - FIFO pointers cleared and FSM to IDLE.
  - Partially sent byte is abandoned, with no stop bit.
- FIFO push:
  - A word is accepted when write=1 and full=0 at a rising edge.
  - write=1 with full=1 drops the word, sets overflow and leaves the FIFO unchanged.
  - full is evaluated from the registered value. A pop in the same cycle does not make room for that cycle's write.
- FSM states:
  - IDLE: tx=1. If FIFO non-empty, pop the head word into a 32-bit shift register, set byte_idx=0, go to START.
  - START: tx=0 for one bit period, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0] for each of PAYLOAD_BITS bit periods, shifting right by 1 after each.
  - STOP: tx=1 for one bit period. Then:
    - byte_idx < WORD_SIZE_BY-1: increment byte_idx and go to START.
    - last byte, FIFO non-empty: pop next word and go to START (no idle gap).
    - last byte, FIFO empty: go to IDLE.
- Byte order: byte 0 = write_data[7:0], then [15:8], [23:16], [31:24]. Bits go out LSB first within each byte.
- tx is driven from a flop, so there are no combinational glitches.
- Latency from idle and empty: with write sampled at edge N, tx falls at edge N+2. The start bit lasts CYCLES_PER_BIT cycles from there.
- Word duration: WORD_SIZE_BY*(PAYLOAD_BITS+2)*CYCLES_PER_BIT cycles (40 bit periods by default).
- busy:
  - Rises at edge N+1 after the first accepted write.
  - Falls at the edge where STOP of the last byte ends with the FIFO empty.
- FIFO wrap-around: pointers are log2(BUFFER_SIZE)+1 bits.
  - full when the low bits are equal and the MSBs differ.
  - empty when the pointers are equal.
- Simultaneous push and pop with FIFO at 1 word: both take effect and occupancy is unchanged.
- overflow clears only on reset.

Test Plan:
All scenarios use CLK_FREQ=100, BIT_RATE=10 (10 cycles/bit).
1. Single word: write 0xA5C30F81 once from idle.
   - Expected: tx low at edge N+2.
   - Bytes decode as 0x81, 0x0F, 0xC3, 0xA5, each with start=0 and stop=1.
   - 400 cycles total; busy falls at the end; tx stays 1 afterwards.
2. Back-to-back: write 0x00000001 then 0xFFFFFFFF on consecutive cycles.
   - Expected: 8 contiguous frames with no idle gap, 800 cycles.
   - Second-word bytes all 0xFF.
3. Full/overflow: with BUFFER_SIZE=8, write 10 words 0..9 on consecutive cycles while the first is transmitting.
   - Expected: full=1 after the 9th accepted push (1 in the shift register, 8 in the FIFO); words 9+ dropped.
   - overflow=1 and stays 1.
   - Serial output is words 0..8 in order.
4. Full release: at full=1, hold write high with 0x12345678.
   - Expected: not accepted in the pop cycle.
   - Accepted on the following edge, and transmitted last.
5. Reset mid-frame: assert reset during DATA of byte 2.
   - Expected: tx=1 immediately (async, before the next edge), busy=0, full=0, overflow=0.
   - After release, a new write 0x0000005A sends 0x5A, 0x00, 0x00, 0x00 only.
6. Wrap-around: push and drain 20 single words 0x100+i.
   - Expected: all 20 received in order.
   - full never asserts and the pointers wrap correctly.

Source files
------------

// File: rtl/uart_word_tx.sv
// Word-oriented UART transmitter: 32-bit words are queued in a small FIFO and
// sent least-significant byte first as 8N1 frames on tx.
`timescale 1ns/1ps

module uart_word_tx #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUFFER_SIZE  = 8,
  parameter int WORD_SIZE_BY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [31:0] write_data,
  output logic        full,
  output logic        busy,
  output logic        overflow,
  output logic        tx
);

  localparam int CYCLES_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int CW = $clog2(CYCLES_PER_BIT + 1);
  localparam int BW = $clog2(PAYLOAD_BITS + 1);
  localparam int YW = $clog2(WORD_SIZE_BY + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [31:0]     mem [BUFFER_SIZE];
  logic [AW:0]     wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic            empty, push, pop, bit_end;
  logic            tx_next, busy_next, full_next;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_idx;
  logic [YW-1:0]   byte_idx;
  logic [31:0]     shift;

  // full is the registered flag, so a pop in this cycle cannot admit this cycle's write.
  assign push    = write & ~full;
  assign empty   = (wr_ptr == rd_ptr);
  assign bit_end = (cnt == '0);

  assign wr_ptr_next = wr_ptr + (AW+1)'(push);
  assign rd_ptr_next = rd_ptr + (AW+1)'(pop);
  assign full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                       (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  assign busy_next   = (state_next != IDLE) || !empty;

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned and no latch is inferred.
    state_next = state;
    pop        = 1'b0;
    tx_next    = 1'b1;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx_next = shift[0];
        if (bit_end && bit_idx == BW'(PAYLOAD_BITS - 1)) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx != YW'(WORD_SIZE_BY - 1)) begin
            state_next = START;
          end else if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: FIFO storage is deliberately not reset; the pointers alone define
    // which entries are valid.
    if (push) mem[wr_ptr[AW-1:0]] <= write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      tx       <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shift    <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      full   <= full_next;
      busy   <= busy_next;
      tx     <= tx_next;
      if (write && full) overflow <= 1'b1;

      if (pop) begin
        shift    <= mem[rd_ptr[AW-1:0]];
        byte_idx <= '0;
        cnt      <= CW'(CYCLES_PER_BIT - 1);
      end else if (state != IDLE) begin
        if (bit_end) begin
          cnt <= CW'(CYCLES_PER_BIT - 1);
          unique case (state)
            START: bit_idx <= '0;
            DATA: begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + BW'(1);
            end
            STOP:    byte_idx <= byte_idx + YW'(1);
            default: ;
          endcase
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: a queue-based transmit model checked
// every cycle, a serial decoder, and directed scenarios with literal expectations.
`timescale 1ns/1ps

module tb_uart_word_tx;

  localparam int CPB      = 10;
  localparam int BUF      = 8;
  localparam int WORD_CYC = 4 * 10 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [31:0] write_data;
  logic        full, busy, overflow, tx;

  int checks = 0;
  int errors = 0;

  uart_word_tx #(
    .CLK_FREQ(100), .BIT_RATE(10), .PAYLOAD_BITS(8),
    .BUFFER_SIZE(BUF), .WORD_SIZE_BY(4)
  ) dut (
    .clk(clk), .reset(reset), .write(write), .write_data(write_data),
    .full(full), .busy(busy), .overflow(overflow), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending words, engine time left on the current word,
  // and the exact tx level for each future cycle.
  logic [31:0] m_q[$];
  bit          m_line[$];
  int          m_left;
  logic        m_tx, m_busy, m_full, m_ovf;
  bit          pre_empty, pre_full, m_idle, m_ending;
  logic [31:0] m_w;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete(); m_line.delete();
      m_left = 0; m_tx = 1'b1; m_busy = 1'b0; m_full = 1'b0; m_ovf = 1'b0;
    end else begin
      pre_empty = (m_q.size() == 0);
      pre_full  = m_full;
      m_tx      = (m_line.size() > 0) ? m_line.pop_front() : 1'b1;
      m_idle    = (m_left == 0);
      m_ending  = (m_left == 1);
      if (m_left > 0) m_left--;
      if ((m_idle || m_ending) && !pre_empty) begin
        m_w    = m_q.pop_front();
        m_left = WORD_CYC;
        for (int b = 0; b < 4; b++) begin
          repeat (CPB) m_line.push_back(1'b0);
          for (int k = 0; k < 8; k++) repeat (CPB) m_line.push_back(m_w[8*b+k]);
          repeat (CPB) m_line.push_back(1'b1);
        end
      end
      if (write) begin
        if (!pre_full) m_q.push_back(write_data);
        else           m_ovf = 1'b1;
      end
      m_full = (m_q.size() == BUF);
      m_busy = (m_left > 0) || !pre_empty;
    end
  end

  int busy_cycles = 0;
  bit saw_full    = 1'b0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("cyc_tx", tx, m_tx);
      check("cyc_busy", busy, m_busy);
      check("cyc_full", full, m_full);
      check("cyc_overflow", overflow, m_ovf);
      if (busy) busy_cycles++;
      if (full) saw_full = 1'b1;
    end
  end

  // Serial decoder: mid-bit sampling of each 8N1 frame.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_byte;
  bit         rx_active, prev_tx;
  int         rx_cnt, rx_k, frame_err = 0;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      rx_active = 1'b0; prev_tx = 1'b1; rx_cnt = 0;
    end else begin
      if (!rx_active) begin
        if (prev_tx && !tx) begin rx_active = 1'b1; rx_cnt = 0; end
      end else rx_cnt++;
      if (rx_active && (rx_cnt % CPB) == CPB/2) begin
        rx_k = rx_cnt / CPB;
        if (rx_k == 0) begin
          if (tx !== 1'b0) frame_err++;
        end else if (rx_k <= 8) begin
          rx_byte[rx_k-1] = tx;
        end else begin
          if (tx !== 1'b1) frame_err++;
          rx_q.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
      prev_tx = tx;
    end
  end

  task automatic expect_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic check_rx(input string name);
    int n;
    check({name, "_nbytes"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
    check({name, "_frame_err"}, frame_err, 0);
    rx_q.delete(); exp_q.delete(); frame_err = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!busy && n < 8) begin @(negedge clk); n++; end
    check({name, "_busy_rose"}, busy, 1'b1);
    n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    check({name, "_idle"}, busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; write = 1'b0; write_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single word, latency and byte order
    busy_cycles = 0;
    write = 1'b1; write_data = 32'hA5C30F81;
    @(negedge clk); write = 1'b0;
    check("s1_tx_at_n", tx, 1'b1);
    check("s1_busy_at_n", busy, 1'b0);
    @(negedge clk);
    check("s1_tx_at_n1", tx, 1'b1);
    check("s1_busy_at_n1", busy, 1'b1);
    @(negedge clk);
    check("s1_tx_at_n2", tx, 1'b0);
    wait_idle("s1", 1000);
    check("s1_busy_cycles", busy_cycles, 400);
    exp_q.push_back(8'h81); exp_q.push_back(8'h0F);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hA5);
    check_rx("s1");
    repeat (20) @(negedge clk);
    check("s1_tx_idle", tx, 1'b1);

    // 2: back-to-back words, no idle gap
    busy_cycles = 0;
    write = 1'b1; write_data = 32'h00000001;
    @(negedge clk); write_data = 32'hFFFFFFFF;
    @(negedge clk); write = 1'b0;
    wait_idle("s2", 2000);
    check("s2_busy_cycles", busy_cycles, 800);
    expect_word(32'h00000001);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
    check_rx("s2");

    // 3 + 4: fill to full, overflow, then release with a held write
    for (int i = 0; i < 10; i++) begin
      write = 1'b1; write_data = i;
      @(negedge clk);
      if (i == 7) check("s3_full_after_8", full, 1'b0);
      if (i == 8) check("s3_full_after_9", full, 1'b1);
    end
    check("s3_overflow", overflow, 1'b1);
    write_data = 32'h12345678;
    for (int n = 0; n < 1000 && full; n++) @(negedge clk);
    check("s4_full_released", full, 1'b0);
    @(negedge clk); write = 1'b0;
    check("s4_full_after_accept", full, 1'b1);
    wait_idle("s4", 6000);
    for (int i = 0; i < 9; i++) expect_word(i);
    expect_word(32'h12345678);
    check_rx("s34");
    check("s4_overflow_sticky", overflow, 1'b1);

    // 5: reset mid-frame during byte 2 data
    write = 1'b1; write_data = 32'h00000000;
    @(negedge clk); write = 1'b0;
    repeat (250) @(negedge clk);
    check("s5_tx_in_data", tx, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("s5_rst_tx", tx, 1'b1);
    check("s5_rst_busy", busy, 1'b0);
    check("s5_rst_full", full, 1'b0);
    check("s5_rst_overflow", overflow, 1'b0);
    @(negedge clk); reset = 1'b1;
    rx_q.delete(); frame_err = 0;
    @(negedge clk);
    busy_cycles = 0;
    write = 1'b1; write_data = 32'h0000005A;
    @(negedge clk); write = 1'b0;
    wait_idle("s5", 1000);
    check("s5_busy_cycles", busy_cycles, 400);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    check_rx("s5");

    // 6: pointer wrap-around over 20 single words
    saw_full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      write = 1'b1; write_data = 32'h100 + i;
      @(negedge clk); write = 1'b0;
      wait_idle($sformatf("s6_w%0d", i), 1000);
      expect_word(32'h100 + i);
    end
    check_rx("s6");
    check("s6_never_full", saw_full, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
